// File: rtl/pipe_ex_sched.sv
// rtl/pipe_ex_sched.sv - round-robin, credit-gated scheduler feeding a 3-stage F=(A+B)+(C-D)+D pipe and result FIFO
module pipe_ex_sched #(
    parameter int N     = 10,
    parameter int DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         req0_valid_i,
    output logic         req0_ready_o,
    input  logic [N-1:0] req0_a_i,
    input  logic [N-1:0] req0_b_i,
    input  logic [N-1:0] req0_c_i,
    input  logic [N-1:0] req0_d_i,
    input  logic         req1_valid_i,
    output logic         req1_ready_o,
    input  logic [N-1:0] req1_a_i,
    input  logic [N-1:0] req1_b_i,
    input  logic [N-1:0] req1_c_i,
    input  logic [N-1:0] req1_d_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [N-1:0] out_f_o,
    output logic         out_tag_o,
    output logic         busy_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int OW = AW + 2;

    logic          s1_v_q, s1_v_d, s1_tag_q, s1_tag_d;
    logic [N-1:0]  s1_x1_q, s1_x1_d, s1_x2_q, s1_x2_d, s1_dd_q, s1_dd_d;
    logic          s2_v_q, s2_v_d, s2_tag_q, s2_tag_d;
    logic [N-1:0]  s2_x3_q, s2_x3_d, s2_dd_q, s2_dd_d;
    logic          s3_v_q, s3_v_d, s3_tag_q, s3_tag_d;
    logic [N-1:0]  s3_f_q, s3_f_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          rr_last_q, rr_last_d;
    logic [N-1:0]  mem_f_q [DEPTH];
    logic [DEPTH-1:0] mem_tag_q;

    logic [OW-1:0] occupancy;
    logic          issue_ok, gnt0, gnt1, push, pop;

    always_comb begin
        // Each op holds a credit from accept until it is popped; a pop this cycle frees it next cycle.
        occupancy = OW'(s1_v_q) + OW'(s2_v_q) + OW'(s3_v_q) + OW'(count_q);
        issue_ok  = occupancy < OW'(DEPTH);
        gnt0      = issue_ok && req0_valid_i && (!req1_valid_i || rr_last_q);
        gnt1      = issue_ok && req1_valid_i && (!req0_valid_i || !rr_last_q);
        push      = s3_v_q;
        pop       = (count_q != '0) && out_ready_i;

        rr_last_d = rr_last_q;
        if (gnt0) begin
            rr_last_d = 1'b0;
        end else if (gnt1) begin
            rr_last_d = 1'b1;
        end

        s1_v_d   = gnt0 || gnt1;
        s1_tag_d = gnt1;
        s1_x1_d  = gnt1 ? req1_a_i + req1_b_i : req0_a_i + req0_b_i;
        s1_x2_d  = gnt1 ? req1_c_i - req1_d_i : req0_c_i - req0_d_i;
        s1_dd_d  = gnt1 ? req1_d_i : req0_d_i;

        s2_v_d   = s1_v_q;
        s2_tag_d = s1_tag_q;
        s2_x3_d  = s1_x1_q + s1_x2_q;
        s2_dd_d  = s1_dd_q;

        s3_v_d   = s2_v_q;
        s3_tag_d = s2_tag_q;
        s3_f_d   = s2_x3_q + s2_dd_q;

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_v_q    <= 1'b0;
            s2_v_q    <= 1'b0;
            s3_v_q    <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rr_last_q <= 1'b1;
        end else begin
            s1_v_q    <= s1_v_d;
            s2_v_q    <= s2_v_d;
            s3_v_q    <= s3_v_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rr_last_q <= rr_last_d;
        end
    end

    // Datapath registers need no reset: the valid bits qualify them.
    always_ff @(posedge clk_i) begin
        s1_tag_q <= s1_tag_d;
        s1_x1_q  <= s1_x1_d;
        s1_x2_q  <= s1_x2_d;
        s1_dd_q  <= s1_dd_d;
        s2_tag_q <= s2_tag_d;
        s2_x3_q  <= s2_x3_d;
        s2_dd_q  <= s2_dd_d;
        s3_tag_q <= s3_tag_d;
        s3_f_q   <= s3_f_d;
        if (push) begin
            mem_f_q[wr_ptr_q]   <= s3_f_q;
            mem_tag_q[wr_ptr_q] <= s3_tag_q;
        end
    end

    assign req0_ready_o = gnt0;
    assign req1_ready_o = gnt1;
    assign out_valid_o  = count_q != '0;
    assign out_f_o      = mem_f_q[rd_ptr_q];
    assign out_tag_o    = mem_tag_q[rd_ptr_q];
    assign busy_o       = s1_v_q || s2_v_q || s3_v_q || (count_q != '0);
endmodule

// File: tb/tb_pipe_ex_sched.sv
// tb/tb_pipe_ex_sched.sv - scoreboard bench for pipe_ex_sched
module tb_pipe_ex_sched;
    localparam int N     = 10;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, req0_valid, req0_ready, req1_valid, req1_ready;
    logic [N-1:0] a0, b0, c0, d0, a1, b1, c1, d1;
    logic         out_valid, out_ready, out_tag, busy;
    logic [N-1:0] out_f;

    pipe_ex_sched #(.N(N), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst),
        .req0_valid_i(req0_valid), .req0_ready_o(req0_ready),
        .req0_a_i(a0), .req0_b_i(b0), .req0_c_i(c0), .req0_d_i(d0),
        .req1_valid_i(req1_valid), .req1_ready_o(req1_ready),
        .req1_a_i(a1), .req1_b_i(b1), .req1_c_i(c1), .req1_d_i(d1),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_f_o(out_f), .out_tag_o(out_tag), .busy_o(busy)
    );

    int           checks = 0;
    int           failures = 0;
    logic [N:0]   sb[$];
    logic         acc0, acc1, popped;
    logic [N:0]   got, exp_e;

    function automatic logic [N-1:0] model(input logic [N-1:0] a, b, c, d);
        logic [N-1:0] t;
        t = a + b + (c - d) + d;
        return t;
    endfunction

    task automatic next();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called once per cycle, #1 after inputs settle: logs accepts into the scoreboard.
    task automatic observe();
        acc0   = req0_valid && req0_ready;
        acc1   = req1_valid && req1_ready;
        if (acc0) sb.push_back({1'b0, model(a0, b0, c0, d0)});
        if (acc1) sb.push_back({1'b1, model(a1, b1, c1, d1)});
        popped = out_valid && out_ready;
        got    = {out_tag, out_f};
    endtask

    task automatic new0();
        a0 = N'($urandom_range(0, 2**N-1)); b0 = N'($urandom_range(0, 2**N-1));
        c0 = N'($urandom_range(0, 2**N-1)); d0 = N'($urandom_range(0, 2**N-1));
    endtask

    task automatic new1();
        a1 = N'($urandom_range(0, 2**N-1)); b1 = N'($urandom_range(0, 2**N-1));
        c1 = N'($urandom_range(0, 2**N-1)); d1 = N'($urandom_range(0, 2**N-1));
    endtask

    task automatic do_reset();
        rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b0;
        acc0 = 1'b0; acc1 = 1'b0;
        next();
        next();
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (req0_ready !== 1'b0) begin failures++; $display("FAIL reset_req0_ready got=%b exp=0", req0_ready); end
        checks++; if (req1_ready !== 1'b0) begin failures++; $display("FAIL reset_req1_ready got=%b exp=0", req1_ready); end
        next();
    endtask

    task automatic test_single();
        int first;
        do_reset();
        out_ready = 1'b1; req0_valid = 1'b1;
        a0 = 10'd5; b0 = 10'd3; c0 = 10'd10; d0 = 10'd4;
        #1; observe();
        checks++; if (acc0 !== 1'b1) begin failures++; $display("FAIL single_accept got=%b exp=1", acc0); end
        next();
        req0_valid = 1'b0;
        first = 0;
        for (int k = 1; k <= 12; k++) begin
            #1; observe();
            if (out_valid && first == 0) first = k;
            if (popped) begin
                checks++; if (got !== {1'b0, 10'd18}) begin failures++; $display("FAIL single_result got=%h exp=%h", got, {1'b0, 10'd18}); end
                exp_e = (sb.size() != 0) ? sb.pop_front() : 'x;
                checks++; if (got !== exp_e) begin failures++; $display("FAIL single_sb got=%h exp=%h", got, exp_e); end
            end
            next();
        end
        checks++; if (first !== 4) begin failures++; $display("FAIL single_latency got=%0d exp=4", first); end
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL single_leftover got=%0d exp=0", sb.size()); end
    endtask

    task automatic test_wrap();
        logic [N-1:0] exp_c [2];
        int idx;
        exp_c[0] = 10'd0; exp_c[1] = 10'd9;
        out_ready = 1'b1; req0_valid = 1'b1;
        a0 = 10'd1023; b0 = 10'd1; c0 = 10'd0; d0 = 10'd1;
        #1; observe();
        checks++; if (acc0 !== 1'b1) begin failures++; $display("FAIL wrap_accept0 got=%b exp=1", acc0); end
        next();
        a0 = 10'd7; b0 = 10'd2; c0 = 10'd0; d0 = 10'd9;
        #1; observe();
        checks++; if (acc0 !== 1'b1) begin failures++; $display("FAIL wrap_accept1 got=%b exp=1", acc0); end
        next();
        req0_valid = 1'b0; idx = 0;
        for (int k = 0; k < 12 && sb.size() != 0; k++) begin
            #1; observe();
            if (popped) begin
                checks++; if (got !== {1'b0, exp_c[idx]}) begin failures++; $display("FAIL wrap_result got=%h exp=%h", got, {1'b0, exp_c[idx]}); end
                exp_e = sb.pop_front();
                checks++; if (got !== exp_e) begin failures++; $display("FAIL wrap_sb got=%h exp=%h", got, exp_e); end
                if (idx < 1) idx++;
            end
            next();
        end
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL wrap_leftover got=%0d exp=0", sb.size()); end
    endtask

    task automatic test_round_robin();
        int  ngr;
        logic exp_tag;
        do_reset();
        out_ready = 1'b1; new0(); new1(); req0_valid = 1'b1; req1_valid = 1'b1;
        ngr = 0; exp_tag = 1'b0;
        for (int k = 0; k < 40 && ngr < 8; k++) begin
            if (acc0) new0();
            if (acc1) new1();
            #1; observe();
            checks++; if ((acc0 && acc1) !== 1'b0) begin failures++; $display("FAIL rr_two_ready got=1 exp=0"); end
            if (acc0 || acc1) begin
                checks++; if (acc1 !== exp_tag) begin failures++; $display("FAIL rr_grant_order got=%b exp=%b", acc1, exp_tag); end
                exp_tag = ~exp_tag; ngr++;
            end
            if (popped) begin
                exp_e = (sb.size() != 0) ? sb.pop_front() : 'x;
                checks++; if (got !== exp_e) begin failures++; $display("FAIL rr_sb got=%h exp=%h", got, exp_e); end
            end
            next();
        end
        checks++; if (ngr != 8) begin failures++; $display("FAIL rr_grant_count got=%0d exp=8", ngr); end
        req0_valid = 1'b0; req1_valid = 1'b0;
        for (int k = 0; k < 20 && sb.size() != 0; k++) begin
            #1; observe();
            if (popped) begin
                exp_e = sb.pop_front();
                checks++; if (got !== exp_e) begin failures++; $display("FAIL rr_drain got=%h exp=%h", got, exp_e); end
            end
            next();
        end
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL rr_leftover got=%0d exp=0", sb.size()); end
    endtask

    task automatic test_credit();
        int nacc;
        do_reset();
        out_ready = 1'b0; new0(); req0_valid = 1'b1; nacc = 0;
        for (int k = 0; k < 10; k++) begin
            if (acc0) new0();
            #1; observe();
            if (acc0) nacc++;
            next();
        end
        checks++; if (nacc != DEPTH) begin failures++; $display("FAIL credit_accepts got=%0d exp=%0d", nacc, DEPTH); end
        if (acc0) new0();
        #1; observe();
        checks++; if (req0_ready !== 1'b0) begin failures++; $display("FAIL credit_full_ready got=%b exp=0", req0_ready); end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL credit_out_valid got=%b exp=1", out_valid); end
        next();
        out_ready = 1'b1;
        #1; observe();
        checks++; if (req0_ready !== 1'b0) begin failures++; $display("FAIL credit_pop_same_cycle got=%b exp=0", req0_ready); end
        exp_e = (sb.size() != 0) ? sb.pop_front() : 'x;
        checks++; if (!popped || got !== exp_e) begin failures++; $display("FAIL credit_pop got=%h exp=%h", got, exp_e); end
        next();
        out_ready = 1'b0;
        #1; observe();
        checks++; if (acc0 !== 1'b1) begin failures++; $display("FAIL credit_reissue got=%b exp=1", acc0); end
        next();
        new0();
        #1; observe();
        checks++; if (req0_ready !== 1'b0) begin failures++; $display("FAIL credit_refull got=%b exp=0", req0_ready); end
        next();
        req0_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 20 && sb.size() != 0; k++) begin
            #1; observe();
            if (popped) begin
                exp_e = sb.pop_front();
                checks++; if (got !== exp_e) begin failures++; $display("FAIL credit_drain got=%h exp=%h", got, exp_e); end
            end
            next();
        end
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL credit_leftover got=%0d exp=0", sb.size()); end
    endtask

    task automatic test_push_pop_wrap();
        logic exp_busy;
        int   npop;
        do_reset();
        npop = 0;
        for (int k = 0; k < 80; k++) begin
            // Hold a pending request; otherwise re-roll valid and operands.
            if (!(req0_valid && !acc0)) begin req0_valid = 1'($urandom_range(0, 1)); new0(); end
            if (!(req1_valid && !acc1)) begin req1_valid = 1'($urandom_range(0, 1)); new1(); end
            out_ready = 1'($urandom_range(0, 1));
            exp_busy = sb.size() != 0;
            #1; observe();
            checks++; if (busy !== exp_busy) begin failures++; $display("FAIL ppw_busy got=%b exp=%b", busy, exp_busy); end
            if (popped) begin
                exp_e = (sb.size() != 0) ? sb.pop_front() : 'x;
                checks++; if (got !== exp_e) begin failures++; $display("FAIL ppw_order got=%h exp=%h", got, exp_e); end
                npop++;
            end
            next();
        end
        req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 20 && sb.size() != 0; k++) begin
            #1; observe();
            if (popped) begin
                exp_e = sb.pop_front();
                checks++; if (got !== exp_e) begin failures++; $display("FAIL ppw_drain got=%h exp=%h", got, exp_e); end
                npop++;
            end
            next();
        end
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL ppw_leftover got=%0d exp=0", sb.size()); end
        checks++; if (npop <= DEPTH) begin failures++; $display("FAIL ppw_no_wrap got=%0d exp>%0d", npop, DEPTH); end
    endtask

    task automatic test_reset_mid();
        int seen;
        do_reset();
        out_ready = 1'b0; new0(); req0_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (acc0) new0();
            #1; observe();
            next();
        end
        req0_valid = 1'b0;
        #1; observe();
        next();
        #1;
        checks++; if (busy !== 1'b1 || out_valid !== 1'b1) begin failures++; $display("FAIL mid_preload got=%b%b exp=11", busy, out_valid); end
        rst = 1'b1; sb.delete();
        next();
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_out_valid got=%b exp=0", out_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b exp=0", busy); end
        next();
        out_ready = 1'b1; seen = 0;
        for (int k = 0; k < 6; k++) begin
            #1; observe();
            if (out_valid) seen++;
            next();
        end
        checks++; if (seen != 0) begin failures++; $display("FAIL mid_ghost_results got=%0d exp=0", seen); end
        new0(); new1(); req0_valid = 1'b1; req1_valid = 1'b1;
        #1; observe();
        checks++; if ({acc0, acc1} !== 2'b10) begin failures++; $display("FAIL mid_first_tie got=%b%b exp=10", acc0, acc1); end
        next();
        req0_valid = 1'b0; req1_valid = 1'b0;
        for (int k = 0; k < 12 && sb.size() != 0; k++) begin
            #1; observe();
            if (popped) begin
                exp_e = sb.pop_front();
                checks++; if (got !== exp_e) begin failures++; $display("FAIL mid_drain got=%h exp=%h", got, exp_e); end
            end
            next();
        end
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL mid_leftover got=%0d exp=0", sb.size()); end
    endtask

    initial begin
        rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b0;
        a0 = '0; b0 = '0; c0 = '0; d0 = '0; a1 = '0; b1 = '0; c1 = '0; d1 = '0;
        test_reset();
        test_single();
        test_wrap();
        test_round_robin();
        test_credit();
        test_push_pop_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end
endmodule
